nn_cfg_loader: RTL and testbench
================================

NN_CFG_LOADER -- requirements
Module: nn_cfg_loader

Interface
REQ-001 SHALL have parameter dataWidth, default 16, neuron data width; payload bits above dataWidth pass through unchanged.
REQ-002 SHALL have parameter MAX_LAYERS, default 4, number of implemented layers.
REQ-003 SHALL have parameter MAX_NEURONS, default 32, maximum neurons per layer.
REQ-004 SHALL have parameter MAX_WEIGHTS, default 784, maximum weights per neuron.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-low (asserted at 0).
REQ-007 SHALL have ports s_data (input, 32, configuration word stream), s_valid (input, 1) and s_ready (output, 1).
REQ-008 SHALL have ports weightValid (output, 1) and weightValue (output, 32), the weight strobe and word.
REQ-009 SHALL have ports biasValid (output, 1) and biasValue (output, 32), the bias strobe and word.
REQ-010 SHALL have ports config_layer_num (output, 32) and config_neuron_num (output, 32), the neuron select.
REQ-011 SHALL have ports block_done (output, 1, one-cycle pulse per finished block) and blk_err (output, 1, one-cycle pulse per rejected block).

Function
REQ-012 SHALL transfer a word only on a cycle with s_valid=1 and s_ready=1; s_ready SHALL be 1 whenever rst is deasserted, so the block accepts one word per cycle.
REQ-013 SHALL decode each header word by fields: [31:30] op (01 weight block, 10 bias block, 00/11 NOP), [29:24] layer, [23:14] neuron, [13:0] count.
REQ-014 SHALL use states IDLE (await header), WEIGHT, BIAS and DRAIN (discard payload).
REQ-015 On an accepted weight header at cycle N, SHALL load config_layer_num and config_neuron_num (zero-extended) at N+1 and enter WEIGHT with remaining=count.
REQ-016 On an accepted weight header with count=0, SHALL pulse block_done at N+1 and stay in IDLE.
REQ-017 In WEIGHT, each word accepted at cycle M SHALL produce weightValid=1 and weightValue=s_data at M+1, then decrement remaining.
REQ-018 After the last weight word is accepted, SHALL pulse block_done in the same cycle as the final weightValid and return to IDLE.
REQ-019 A bias header SHALL ignore count, enter BIAS and take exactly one payload word, giving biasValid=1 and biasValue=word plus block_done one cycle after acceptance.
REQ-020 A NOP header SHALL be consumed with no output change and no pulse.
REQ-021 config_layer_num, config_neuron_num, weightValue and biasValue SHALL hold between strobes; strobes SHALL be single-cycle and never both high in the same cycle.
REQ-022 Idle cycles (s_valid=0) inside a block SHALL pause the block with no strobe and no state loss.

Reset
REQ-023 While rst=0, SHALL set state=IDLE, s_ready=0, remaining=0 and every output to 0.
REQ-024 Reset mid-block SHALL discard the partial block with no block_done; re-initialising neurons is the system's job.

Configuration
REQ-025 With macro NN_CFG_BOUNDS_CHECK_EN defined, SHALL reject a weight or bias header with layer>=MAX_LAYERS or neuron>=MAX_NEURONS.
REQ-026 With NN_CFG_BOUNDS_CHECK_EN defined, SHALL also reject a weight header with count=0 or count>MAX_WEIGHTS.
REQ-027 On rejection, SHALL pulse blk_err at N+1, leave the config outputs unchanged and enter DRAIN.
REQ-028 DRAIN SHALL consume count payload words (1 for bias; none if count=0) with no strobes, then return to IDLE.
REQ-029 With NN_CFG_BOUNDS_CHECK_EN undefined, SHALL accept every header, never use DRAIN, and tie blk_err to 0.

Structure
REQ-030 Package nn_cfg_pkg SHALL hold op-code constants, header field bit positions/widths and the state enum.
REQ-031 Sub-module nn_cfg_hdr_decode SHALL be combinational: s_data in; op, layer, neuron, count and a reject flag out.
REQ-032 The down-counter for remaining SHALL be 14 bits.

Verification
REQ-033 Header op=01, L=1, N=2, cnt=3, then 0xA, 0xB, 0xC back-to-back -> config 1/2 one cycle after the header; weightValid for 3 consecutive cycles with 0xA, 0xB, 0xC; block_done with the third.
REQ-034 Bias header L=0, N=5, then 0xFFFF0010 -> one biasValid with biasValue=0xFFFF0010 plus block_done; weightValid stays 0.
REQ-035 Weight block cnt=2 with s_valid low for 3 cycles between the payloads -> exactly 2 strobes and outputs held during the gap.
REQ-036 Reset pulse after 1 of 3 weights, then a NOP and a cnt=1 block -> no block_done for the aborted block; the new block completes normally.
REQ-037 With NN_CFG_BOUNDS_CHECK_EN, header L=7 cnt=2 plus 2 words -> blk_err once, no strobes, config unchanged; the next valid block works.
REQ-038 Without NN_CFG_BOUNDS_CHECK_EN, the same L=7 stimulus -> config_layer_num=7 and 2 weightValid strobes.

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// Shared definitions for the neural-network configuration loader:
// header field layout, op-codes and the loader state encoding.
package nn_cfg_pkg;

   localparam logic [1:0] OP_WEIGHT = 2'b01;
   localparam logic [1:0] OP_BIAS   = 2'b10;

   localparam int OP_LSB     = 30;
   localparam int OP_W       = 2;
   localparam int LAYER_LSB  = 24;
   localparam int LAYER_W    = 6;
   localparam int NEURON_LSB = 14;
   localparam int NEURON_W   = 10;
   localparam int COUNT_LSB  = 0;
   localparam int COUNT_W    = 14;

   typedef enum logic [1:0] {
      IDLE,
      WEIGHT,
      BIAS,
      DRAIN
   } state_t;

endpackage

// File: rtl/nn_cfg_hdr_decode.sv
// Combinational header decoder. Bounds rejection is active only when
// NN_CFG_BOUNDS_CHECK_EN is defined; otherwise reject is constant 0.
module nn_cfg_hdr_decode
   import nn_cfg_pkg::*;
#(
   parameter int MAX_LAYERS  = 4,
   parameter int MAX_NEURONS = 32,
   parameter int MAX_WEIGHTS = 784
) (
   input  logic [31:0]         s_data,
   output logic [OP_W-1:0]     op,
   output logic [LAYER_W-1:0]  layer,
   output logic [NEURON_W-1:0] neuron,
   output logic [COUNT_W-1:0]  count,
   output logic                reject
);

`ifdef NN_CFG_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   logic bad_addr;
   logic bad_count;

   assign op     = s_data[OP_LSB +: OP_W];
   assign layer  = s_data[LAYER_LSB +: LAYER_W];
   assign neuron = s_data[NEURON_LSB +: NEURON_W];
   assign count  = s_data[COUNT_LSB +: COUNT_W];

   assign bad_addr  = (32'(layer) >= 32'(MAX_LAYERS)) || (32'(neuron) >= 32'(MAX_NEURONS));
   assign bad_count = (count == '0) || (32'(count) > 32'(MAX_WEIGHTS));

   // Bias blocks carry no meaningful count, so only the address is checked.
   assign reject = BOUNDS_EN && (((op == OP_WEIGHT) && (bad_addr || bad_count)) ||
                                 ((op == OP_BIAS) && bad_addr));

endmodule

// File: rtl/nn_cfg_loader.sv
// Streams weight/bias configuration words to neurons. Header rejection and
// the DRAIN path are live only with NN_CFG_BOUNDS_CHECK_EN defined.
module nn_cfg_loader
   import nn_cfg_pkg::*;
#(
   parameter int dataWidth   = 16,
   parameter int MAX_LAYERS  = 4,
   parameter int MAX_NEURONS = 32,
   parameter int MAX_WEIGHTS = 784
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic [31:0] weightValue,
   output logic        biasValid,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        block_done,
   output logic        blk_err
);

   state_t               state;
   logic [COUNT_W-1:0]   remaining;
   logic [OP_W-1:0]      hdr_op;
   logic [LAYER_W-1:0]   hdr_layer;
   logic [NEURON_W-1:0]  hdr_neuron;
   logic [COUNT_W-1:0]   hdr_count;
   logic                 hdr_reject;
   logic [31:0]          payload;
   logic                 accept;

   nn_cfg_hdr_decode #(
      .MAX_LAYERS  (MAX_LAYERS),
      .MAX_NEURONS (MAX_NEURONS),
      .MAX_WEIGHTS (MAX_WEIGHTS)
   ) u_hdr_decode (
      .s_data (s_data),
      .op     (hdr_op),
      .layer  (hdr_layer),
      .neuron (hdr_neuron),
      .count  (hdr_count),
      .reject (hdr_reject)
   );

   // Neuron data and any upper sideband bits travel together untouched.
   generate
      if (dataWidth < 32) begin : g_split
         assign payload = {s_data[31:dataWidth], s_data[dataWidth-1:0]};
      end else begin : g_full
         assign payload = s_data;
      end
   endgenerate

   assign s_ready = rst;
   assign accept  = s_valid && s_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         remaining         <= '0;
         weightValid       <= 1'b0;
         weightValue       <= '0;
         biasValid         <= 1'b0;
         biasValue         <= '0;
         config_layer_num  <= '0;
         config_neuron_num <= '0;
         block_done        <= 1'b0;
         blk_err           <= 1'b0;
      end else begin
         weightValid <= 1'b0;
         biasValid   <= 1'b0;
         block_done  <= 1'b0;
         blk_err     <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  if ((hdr_op == OP_WEIGHT) || (hdr_op == OP_BIAS)) begin
                     if (hdr_reject) begin
                        blk_err <= 1'b1;
                        if (hdr_op == OP_BIAS) begin
                           state     <= DRAIN;
                           remaining <= 14'd1;
                        end else if (hdr_count != '0) begin
                           state     <= DRAIN;
                           remaining <= hdr_count;
                        end
                     end else begin
                        config_layer_num  <= 32'(hdr_layer);
                        config_neuron_num <= 32'(hdr_neuron);
                        if (hdr_op == OP_BIAS) begin
                           state <= BIAS;
                        end else if (hdr_count == '0) begin
                           block_done <= 1'b1;
                        end else begin
                           state     <= WEIGHT;
                           remaining <= hdr_count;
                        end
                     end
                  end
               end
               WEIGHT: begin
                  weightValid <= 1'b1;
                  weightValue <= payload;
                  remaining   <= remaining - 14'd1;
                  if (remaining == 14'd1) begin
                     block_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
               BIAS: begin
                  biasValid  <= 1'b1;
                  biasValue  <= payload;
                  block_done <= 1'b1;
                  state      <= IDLE;
               end
               DRAIN: begin
                  remaining <= remaining - 14'd1;
                  if (remaining == 14'd1) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nn_cfg_loader.sv
// Bench for nn_cfg_loader: word streams are parsed block-by-block into an
// expected event list (strobes and output changes with their cycle numbers).
module tb_nn_cfg_loader;

   localparam int L_MAX = 4;
   localparam int N_MAX = 32;
   localparam int W_MAX = 784;
`ifdef NN_CFG_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        weightValid;
   logic [31:0] weightValue;
   logic        biasValid;
   logic [31:0] biasValue;
   logic [31:0] config_layer_num;
   logic [31:0] config_neuron_num;
   logic        block_done;
   logic        blk_err;

   nn_cfg_loader dut (
      .clk               (clk),
      .rst               (rst),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .weightValid       (weightValid),
      .weightValue       (weightValue),
      .biasValid         (biasValid),
      .biasValue         (biasValue),
      .config_layer_num  (config_layer_num),
      .config_neuron_num (config_neuron_num),
      .block_done        (block_done),
      .blk_err           (blk_err)
   );

   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   typedef struct packed {
      logic        wv;
      logic        bv;
      logic        done;
      logic        err;
      logic [31:0] wval;
      logic [31:0] bval;
      logic [31:0] lay;
      logic [31:0] neu;
      logic [31:0] cyc;
   } ev_t;

   ev_t         obs_q[$];
   ev_t         exp_q[$];
   logic [31:0] stim_q[$];
   logic [31:0] acc_cyc[$];
   int          gap_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] m_last_w, m_last_b, m_cfg_l, m_cfg_n;
   logic [31:0] p_w, p_b, p_l, p_n;

   // Record every cycle with a strobe or any change of a held output.
   always @(negedge clk) begin
      if (!rst) begin
         p_w <= '0; p_b <= '0; p_l <= '0; p_n <= '0;
      end else begin
         if (weightValid || biasValid || block_done || blk_err ||
             weightValue !== p_w || biasValue !== p_b ||
             config_layer_num !== p_l || config_neuron_num !== p_n)
            obs_q.push_back({weightValid, biasValid, block_done, blk_err, weightValue,
                             biasValue, config_layer_num, config_neuron_num, cyc});
         p_w <= weightValue; p_b <= biasValue;
         p_l <= config_layer_num; p_n <= config_neuron_num;
      end
   end

   function automatic logic [31:0] hdr(input int op, input int l, input int n, input int c);
      logic [31:0] h;
      h[31:30] = op[1:0];
      h[29:24] = l[5:0];
      h[23:14] = n[9:0];
      h[13:0]  = c[13:0];
      return h;
   endfunction

   function automatic ev_t mk(input logic wv, input logic bv, input logic done,
                              input logic err, input logic [31:0] c);
      ev_t e;
      e.wv = wv; e.bv = bv; e.done = done; e.err = err;
      e.wval = m_last_w; e.bval = m_last_b;
      e.lay = m_cfg_l; e.neu = m_cfg_n; e.cyc = c;
      return e;
   endfunction

   task automatic model_reset();
      m_last_w = '0; m_last_b = '0; m_cfg_l = '0; m_cfg_n = '0;
   endtask

   // Walk the stream as whole blocks: header, then its payload words.
   task automatic build_expected();
      int i = 0;
      exp_q.delete();
      while (i < stim_q.size()) begin
         logic [31:0] h;
         int op, l, n, c, hi;
         bit rej;
         h = stim_q[i]; hi = i; i++;
         op = int'(h[31:30]); l = int'(h[29:24]); n = int'(h[23:14]); c = int'(h[13:0]);
         if (op == 1) begin
            rej = BOUNDS_EN && (l >= L_MAX || n >= N_MAX || c == 0 || c > W_MAX);
            if (rej) begin
               exp_q.push_back(mk(0, 0, 0, 1, acc_cyc[hi]));
               i += c;
            end else begin
               bit chg;
               chg = (m_cfg_l != 32'(l)) || (m_cfg_n != 32'(n));
               m_cfg_l = 32'(l); m_cfg_n = 32'(n);
               if (c == 0) exp_q.push_back(mk(0, 0, 1, 0, acc_cyc[hi]));
               else if (chg) exp_q.push_back(mk(0, 0, 0, 0, acc_cyc[hi]));
               for (int k = 0; k < c && i < stim_q.size(); k++) begin
                  m_last_w = stim_q[i];
                  exp_q.push_back(mk(1, 0, (k == c - 1), 0, acc_cyc[i]));
                  i++;
               end
            end
         end else if (op == 2) begin
            rej = BOUNDS_EN && (l >= L_MAX || n >= N_MAX);
            if (rej) begin
               exp_q.push_back(mk(0, 0, 0, 1, acc_cyc[hi]));
               i += 1;
            end else begin
               if ((m_cfg_l != 32'(l)) || (m_cfg_n != 32'(n))) begin
                  m_cfg_l = 32'(l); m_cfg_n = 32'(n);
                  exp_q.push_back(mk(0, 0, 0, 0, acc_cyc[hi]));
               end
               if (i < stim_q.size()) begin
                  m_last_b = stim_q[i];
                  exp_q.push_back(mk(0, 1, 1, 0, acc_cyc[i]));
                  i++;
               end
            end
         end
      end
   endtask

   task automatic run_stream(input int gap_pct, input string name);
      int idle;
      obs_q.delete(); acc_cyc.delete();
      foreach (stim_q[i]) begin
         @(negedge clk);
         s_valid = 1'b0;
         if (i < gap_q.size()) idle = gap_q[i];
         else begin
            idle = 0;
            while ($urandom_range(99) < gap_pct) idle++;
         end
         repeat (idle) begin
            s_data = $urandom;
            @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = stim_q[i];
         acc_cyc.push_back(cyc + 32'd1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      gap_q.delete();
      build_expected();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s event_count got %0d want %0d", name, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         vectors++;
         if (obs_q[k] !== exp_q[k]) begin
            miscompares++;
            $display("FAIL %s ev%0d got wv=%0b bv=%0b done=%0b err=%0b w=%h b=%h L=%0d N=%0d cyc=%0d want wv=%0b bv=%0b done=%0b err=%0b w=%h b=%h L=%0d N=%0d cyc=%0d",
                     name, k, obs_q[k].wv, obs_q[k].bv, obs_q[k].done, obs_q[k].err,
                     obs_q[k].wval, obs_q[k].bval, obs_q[k].lay, obs_q[k].neu, obs_q[k].cyc,
                     exp_q[k].wv, exp_q[k].bv, exp_q[k].done, exp_q[k].err,
                     exp_q[k].wval, exp_q[k].bval, exp_q[k].lay, exp_q[k].neu, exp_q[k].cyc);
         end
      end
      $display("stream %s: %0d words, %0d events", name, stim_q.size(), obs_q.size());
   endtask

   task automatic check_in_reset(input string name);
      vectors++;
      if ({s_ready, weightValid, biasValid, block_done, blk_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL %s ready/strobes got %b want 00000", name,
                  {s_ready, weightValid, biasValid, block_done, blk_err});
      end
      vectors++;
      if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'd0) begin
         miscompares++;
         $display("FAIL %s values got w=%h b=%h L=%h N=%h want all 0", name,
                  weightValue, biasValue, config_layer_num, config_neuron_num);
      end
   endtask

   task automatic apply_reset(input string name);
      @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_in_reset(name);
      end
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s s_ready_after got %b want 1", name, s_ready);
      end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check_in_reset("reset");
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset s_ready got %b want 1", s_ready);
      end
   endtask

   task automatic test_weight_block();
      stim_q = '{hdr(1, 1, 2, 3), 32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
      run_stream(0, "weight_block");
      stim_q = '{hdr(1, 3, 9, 0)};
      run_stream(0, "weight_count0");
   endtask

   task automatic test_bias();
      stim_q = '{hdr(2, 0, 5, 77), 32'hFFFF_0010};
      run_stream(0, "bias_block");
   endtask

   task automatic test_gap();
      stim_q = '{hdr(1, 2, 7, 2), 32'h1234_5678, 32'h9ABC_DEF0};
      gap_q  = '{0, 0, 3};
      run_stream(0, "gap");
   endtask

   task automatic test_nop();
      stim_q = '{hdr(0, 63, 1023, 5), hdr(3, 1, 1, 2), hdr(2, 1, 4, 0), 32'hCAFE_0001};
      run_stream(0, "nop");
   endtask

   task automatic test_reset_mid_block();
      stim_q = '{hdr(1, 1, 2, 3), 32'h0000_000A};
      run_stream(0, "abort_pre");
      apply_reset("abort_reset");
      stim_q = '{hdr(0, 0, 0, 0), hdr(1, 2, 3, 1), 32'h0000_0055};
      run_stream(0, "abort_post");
   endtask

   task automatic test_bounds();
      stim_q = '{hdr(1, 7, 0, 2), 32'h0000_0011, 32'h0000_0022,
                 hdr(1, 1, 1, 1), 32'h0000_0033,
                 hdr(2, 0, 40, 0), 32'h0000_0044,
                 hdr(1, 0, 0, 0),
                 hdr(1, 2, 2, 1), 32'h0000_0066};
      run_stream(0, "bounds");
   endtask

   task automatic test_back_to_back_random();
      for (int s = 0; s < 4; s++) begin
         stim_q.delete();
         for (int b = 0; b < 6; b++) begin
            int op, l, n, c;
            op = $urandom_range(3);
            l  = $urandom_range(5);
            n  = $urandom_range(40);
            if ($urandom_range(39) == 0) c = W_MAX + $urandom_range(1);
            else if ($urandom_range(7) == 0) c = 0;
            else c = $urandom_range(5, 1);
            stim_q.push_back(hdr(op, l, n, c));
            if (op == 1) for (int k = 0; k < c; k++) stim_q.push_back($urandom);
            else if (op == 2) stim_q.push_back($urandom);
         end
         run_stream((s == 0) ? 0 : 30, $sformatf("random%0d", s));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_weight_block();
      test_bias();
      test_gap();
      test_nop();
      test_reset_mid_block();
      test_bounds();
      test_back_to_back_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
